// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the divider and its controller.
//   - divider FSM state encoding
//   - DIV / DIVU funct codes; the controller derives signed_div from these
package mips_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX
  } div_state_e;

  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  // Controller helper: DIV is signed, DIVU is not.
  function automatic logic funct_is_signed_div(input logic [5:0] funct);
    return funct == FUNCT_DIV;
  endfunction

endpackage

// File: rtl/mips_div_if.sv
// Request/response bundle between the EX-stage controller (master) and the
// divider (slave).
//   start/signed_div/a/b : request, sampled while busy=0
//   cancel               : pipeline flush, aborts an in-flight divide
//   busy                 : stall request
//   done                 : one-cycle result strobe
//   quotient/remainder/div_by_zero : registered results, held until next done
interface mips_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic             signed_div;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_div, cancel, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_div, cancel, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mips_div_step.sv
// One restoring-division step, purely combinational.
//   rem_i  : partial remainder (always < dvs_i)
//   bit_i  : next dividend bit shifted into the remainder
//   dvs_i  : divisor magnitude
//   rem_o  : new partial remainder
//   qbit_o : quotient bit produced by this step
module mips_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  // Because rem_i < dvs_i, the true difference lies in
  // (-2^WIDTH, 2^WIDTH), so bit WIDTH is a valid sign bit.
  assign diff    = shifted - {1'b0, dvs_i};
  assign qbit_o  = ~diff[WIDTH];
  assign rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/mips_div.sv
// Iterative restoring divider for DIV/DIVU (HI = remainder, LO = quotient).
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   dif : mips_div_if.slave request/response bundle
// Latency: WIDTH CALC cycles + one FIX cycle; done is registered.
module mips_div
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mips_div_if.slave   dif
);
  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // |b|
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;   // divide-by-zero request in flight
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  assign a_neg = dif.signed_div & dif.a[WIDTH-1];
  assign b_neg = dif.signed_div & dif.b[WIDTH-1];

  mips_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[WIDTH-1]),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dif.start && !dif.cancel) begin
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          rem_d  = '0;
          cnt_d  = '0;
          if (dif.b == '0) begin
            // Raw a is parked in the dividend register: it is the result.
            zero_d  = 1'b1;
            dvd_d   = dif.a;
            state_d = FIX;
          end else begin
            zero_d  = 1'b0;
            dvd_d   = a_neg ? -dif.a : dif.a;
            dvs_d   = b_neg ? -dif.b : dif.b;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (dif.cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!dif.cancel) begin
          // MIN / -1 needs no special case: -MIN == MIN in WIDTH bits.
          quo_d  = zero_q ? '1    : (qneg_q ? -dvd_q : dvd_q);
          res_d  = zero_q ? dvd_q : (rneg_q ? -rem_q : rem_q);
          dbz_d  = zero_q;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign dif.busy        = (state_q != IDLE);
  assign dif.done        = done_q;
  assign dif.quotient    = quo_q;
  assign dif.remainder   = res_q;
  assign dif.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mips_div.sv
module tb_mips_div;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_div_if #(.WIDTH(32)) d32();
  mips_div_if #(.WIDTH(8))  d8();
  mips_div_if #(.WIDTH(64)) d64();

  mips_div #(.WIDTH(32)) u_div32 (.clk(clk), .rst(rst), .dif(d32.slave));
  mips_div #(.WIDTH(8))  u_div8  (.clk(clk), .rst(rst), .dif(d8.slave));
  mips_div #(.WIDTH(64)) u_div64 (.clk(clk), .rst(rst), .dif(d64.slave));

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- stimulus helpers (no checking inside) ----
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s);
    d32.a = a; d32.b = b; d32.signed_div = s; d32.start = 1'b1;
    tick();
    d32.start = 1'b0;
  endtask

  task automatic wait32(output int lat);
    lat = 1;
    while (d32.done !== 1'b1 && lat < 200) begin tick(); lat++; end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
    d8.a = a; d8.b = b; d8.signed_div = s; d8.start = 1'b1;
    tick();
    d8.start = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 1;
    while (d8.done !== 1'b1 && lat < 200) begin tick(); lat++; end
  endtask

  task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic s);
    d64.a = a; d64.b = b; d64.signed_div = s; d64.start = 1'b1;
    tick();
    d64.start = 1'b0;
  endtask

  task automatic wait64(output int lat);
    lat = 1;
    while (d64.done !== 1'b1 && lat < 300) begin tick(); lat++; end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++; if (d32.busy !== 1'b0 || d32.done !== 1'b0) begin errors++; $display("FAIL reset32_ctl: busy=%b done=%b expected 0/0", d32.busy, d32.done); end
    checks++; if (d32.quotient !== 32'h0 || d32.remainder !== 32'h0 || d32.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset32_out: q=%h r=%h z=%b expected zeros", d32.quotient, d32.remainder, d32.div_by_zero); end
    checks++; if (d8.busy !== 1'b0 || d8.quotient !== 8'h0 || d8.remainder !== 8'h0) begin errors++; $display("FAIL reset8: busy=%b q=%h r=%h expected zeros", d8.busy, d8.quotient, d8.remainder); end
    checks++; if (d64.busy !== 1'b0 || d64.quotient !== 64'h0 || d64.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset64: busy=%b q=%h z=%b expected zeros", d64.busy, d64.quotient, d64.div_by_zero); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_unsigned_basic();
    issue32(32'd100, 32'd7, 1'b0);
    for (int c = 1; c <= 33; c++) begin
      checks++; if (d32.busy !== 1'b1 || d32.done !== 1'b0) begin errors++; $display("FAIL basic_busy c%0d: busy=%b done=%b expected 1/0", c, d32.busy, d32.done); end
      tick();
    end
    checks++; if (d32.done !== 1'b1 || d32.busy !== 1'b0) begin errors++; $display("FAIL basic_done c34: done=%b busy=%b expected 1/0", d32.done, d32.busy); end
    checks++; if (d32.quotient !== 32'd14 || d32.remainder !== 32'd2 || d32.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_result: q=%0d r=%0d z=%b expected 14/2/0", d32.quotient, d32.remainder, d32.div_by_zero); end
    tick();
    checks++; if (d32.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done=%b expected 0", d32.done); end
  endtask

  task automatic test_signed();
    logic [31:0] va [4], vb [4], eq [4], er [4];
    logic        vs [4];
    int lat;
    va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;        vs[0] = 1'b1; eq[0] = 32'hFFFFFFFD; er[0] = 32'hFFFFFFFF;
    va[1] = 32'd7;        vb[1] = 32'hFFFFFFFE; vs[1] = 1'b1; eq[1] = 32'hFFFFFFFD; er[1] = 32'd1;
    va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; vs[2] = 1'b1; eq[2] = 32'h80000000; er[2] = 32'h0;
    va[3] = 32'h80000000; vb[3] = 32'hFFFFFFFF; vs[3] = 1'b0; eq[3] = 32'h0;        er[3] = 32'h80000000;
    for (int i = 0; i < 4; i++) begin
      issue32(va[i], vb[i], vs[i]);
      wait32(lat);
      checks++; if (lat !== 34) begin errors++; $display("FAIL signed_lat%0d: done at %0d expected 34", i, lat); end
      checks++; if (d32.quotient !== eq[i] || d32.remainder !== er[i]) begin errors++; $display("FAIL signed_res%0d: q=%h r=%h expected %h/%h", i, d32.quotient, d32.remainder, eq[i], er[i]); end
      tick();
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    issue32(32'h1234, 32'h0, 1'b0);
    checks++; if (d32.busy !== 1'b1 || d32.done !== 1'b0) begin errors++; $display("FAIL dbz_busy: busy=%b done=%b expected 1/0", d32.busy, d32.done); end
    wait32(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL dbz_lat: done at %0d expected 2", lat); end
    checks++; if (d32.quotient !== 32'hFFFFFFFF || d32.remainder !== 32'h1234 || d32.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_res: q=%h r=%h z=%b expected ffffffff/1234/1", d32.quotient, d32.remainder, d32.div_by_zero); end
    tick();
    issue32(32'hFFFFFFFB, 32'h0, 1'b1);
    wait32(lat);
    checks++; if (d32.remainder !== 32'hFFFFFFFB || d32.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_signed: r=%h z=%b expected fffffffb/1", d32.remainder, d32.div_by_zero); end
    tick();
  endtask

  task automatic test_cancel();
    int ndone = 0;
    issue32(32'd100, 32'd7, 1'b0);
    repeat (9) tick();
    d32.cancel = 1'b1;
    tick();
    d32.cancel = 1'b0;
    checks++; if (d32.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: busy=%b expected 0", d32.busy); end
    for (int i = 0; i < 40; i++) begin if (d32.done === 1'b1) ndone++; tick(); end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL cancel_nodone: %0d dones expected 0", ndone); end
    checks++; if (d32.quotient !== 32'hFFFFFFFF || d32.remainder !== 32'hFFFFFFFB || d32.div_by_zero !== 1'b1) begin errors++; $display("FAIL cancel_hold: q=%h r=%h z=%b expected ffffffff/fffffffb/1", d32.quotient, d32.remainder, d32.div_by_zero); end
  endtask

  task automatic test_collision();
    int ndone = 0;
    d32.a = 32'd100; d32.b = 32'd7; d32.signed_div = 1'b0;
    d32.start = 1'b1; d32.cancel = 1'b1;
    tick();
    d32.start = 1'b0; d32.cancel = 1'b0;
    checks++; if (d32.busy !== 1'b0) begin errors++; $display("FAIL coll_start_cancel: busy=%b expected 0", d32.busy); end
    // start held through the whole divide, dropped in the done cycle
    d32.start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (d32.done === 1'b1) begin
        ndone++;
        d32.start = 1'b0;
        checks++; if (d32.quotient !== 32'd14 || d32.remainder !== 32'd2) begin errors++; $display("FAIL coll_held_res: q=%0d r=%0d expected 14/2", d32.quotient, d32.remainder); end
      end
    end
    d32.start = 1'b0;
    checks++; if (ndone !== 1 || d32.busy !== 1'b0) begin errors++; $display("FAIL coll_held_once: dones=%0d busy=%b expected 1/0", ndone, d32.busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue32(32'd100, 32'd7, 1'b0);
    wait32(lat);
    // accepted in the done cycle because busy is low there
    issue32(32'd200, 32'd9, 1'b0);
    checks++; if (d32.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b expected 1", d32.busy); end
    wait32(lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_lat: done at %0d expected 34", lat); end
    checks++; if (d32.quotient !== 32'd22 || d32.remainder !== 32'd2) begin errors++; $display("FAIL b2b_res: q=%0d r=%0d expected 22/2", d32.quotient, d32.remainder); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    issue32(32'd100, 32'd7, 1'b0);
    repeat (14) tick();
    rst = 1'b0;
    #1;
    checks++; if (d32.busy !== 1'b0 || d32.done !== 1'b0) begin errors++; $display("FAIL rstmid_ctl: busy=%b done=%b expected 0/0", d32.busy, d32.done); end
    checks++; if (d32.quotient !== 32'h0 || d32.remainder !== 32'h0 || d32.div_by_zero !== 1'b0) begin errors++; $display("FAIL rstmid_out: q=%h r=%h z=%b expected zeros", d32.quotient, d32.remainder, d32.div_by_zero); end
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    issue32(32'd1000, 32'd10, 1'b0);
    wait32(lat);
    checks++; if (lat !== 34 || d32.quotient !== 32'd100 || d32.remainder !== 32'd0) begin errors++; $display("FAIL rstmid_after: lat=%0d q=%0d r=%0d expected 34/100/0", lat, d32.quotient, d32.remainder); end
    tick();
  endtask

  task automatic test_width8();
    logic [7:0] a, b, eq, er;
    logic       s, ez;
    int lat, sa, sb, qi, ri;
    for (int i = 0; i < 28; i++) begin
      case (i)
        0: begin a = 8'h80; b = 8'hFF; s = 1'b1; end
        1: begin a = 8'd200; b = 8'd7; s = 1'b0; end
        2: begin a = 8'h9C; b = 8'd7; s = 1'b1; end
        3: begin a = 8'h55; b = 8'h00; s = 1'b1; end
        default: begin a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); s = 1'($urandom_range(0, 1)); end
      endcase
      // reference: native operators truncate toward zero like MIPS
      if (b == 8'h0) begin
        eq = 8'hFF; er = a; ez = 1'b1;
      end else if (s) begin
        sa = {{24{a[7]}}, a}; sb = {{24{b[7]}}, b};
        qi = sa / sb; ri = sa % sb;
        eq = qi[7:0]; er = ri[7:0]; ez = 1'b0;
      end else begin
        sa = {24'h0, a}; sb = {24'h0, b};
        qi = sa / sb; ri = sa % sb;
        eq = qi[7:0]; er = ri[7:0]; ez = 1'b0;
      end
      issue8(a, b, s);
      wait8(lat);
      checks++; if (lat !== (ez ? 2 : 10)) begin errors++; $display("FAIL w8_lat%0d: done at %0d expected %0d", i, lat, ez ? 2 : 10); end
      checks++; if (d8.quotient !== eq || d8.remainder !== er || d8.div_by_zero !== ez) begin errors++; $display("FAIL w8_res%0d a=%h b=%h s=%b: q=%h r=%h z=%b expected %h/%h/%b", i, a, b, s, d8.quotient, d8.remainder, d8.div_by_zero, eq, er, ez); end
      tick();
    end
  endtask

  task automatic test_width64();
    logic [63:0] va [5], vb [5], eq [5], er [5];
    logic        vs [5];
    int lat;
    va[0] = 64'hFFFFFFFFFFFFFFFF; vb[0] = 64'd3; vs[0] = 1'b0; eq[0] = 64'h5555555555555555; er[0] = 64'd0;
    va[1] = 64'hFFFFFFFFFFFFFFFF; vb[1] = 64'd3; vs[1] = 1'b1; eq[1] = 64'd0; er[1] = 64'hFFFFFFFFFFFFFFFF;
    va[2] = 64'h8000000000000000; vb[2] = 64'hFFFFFFFFFFFFFFFF; vs[2] = 1'b1; eq[2] = 64'h8000000000000000; er[2] = 64'd0;
    va[3] = 64'h123456789ABCDEF0; vb[3] = 64'h10; vs[3] = 1'b0; eq[3] = 64'h0123456789ABCDEF; er[3] = 64'd0;
    va[4] = 64'd1000000000000; vb[4] = 64'd0 - 64'd7; vs[4] = 1'b1; eq[4] = 64'd0 - 64'd142857142857; er[4] = 64'd1;
    for (int i = 0; i < 5; i++) begin
      issue64(va[i], vb[i], vs[i]);
      wait64(lat);
      checks++; if (lat !== 66) begin errors++; $display("FAIL w64_lat%0d: done at %0d expected 66", i, lat); end
      checks++; if (d64.quotient !== eq[i] || d64.remainder !== er[i]) begin errors++; $display("FAIL w64_res%0d: q=%h r=%h expected %h/%h", i, d64.quotient, d64.remainder, eq[i], er[i]); end
      tick();
    end
  endtask

  initial begin
    d32.start = 1'b0; d32.cancel = 1'b0; d32.signed_div = 1'b0; d32.a = '0; d32.b = '0;
    d8.start  = 1'b0; d8.cancel  = 1'b0; d8.signed_div  = 1'b0; d8.a  = '0; d8.b  = '0;
    d64.start = 1'b0; d64.cancel = 1'b0; d64.signed_div = 1'b0; d64.a = '0; d64.b = '0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_by_zero();
    test_cancel();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    test_width64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
